// File: rtl/alu_arbiter_if.sv
// Shared ALU operation encoding plus the request/response bundle between the
// two requesters and the ALU arbiter.
package typedefs_pkg;
   typedef enum logic [2:0] {
      ALU_AND = 3'd0,
      ALU_OR  = 3'd1,
      ALU_ADD = 3'd2,
      ALU_XOR = 3'd3,
      ALU_SUB = 3'd6,
      ALU_SLT = 3'd7
   } aluop_sel_t;
endpackage

interface alu_arbiter_if #(parameter int DWIDTH = 8);
   import typedefs_pkg::*;

   logic [1:0]              req_valid;
   logic [1:0]              req_ready;
   logic [1:0][DWIDTH-1:0]  req_src1;
   logic [1:0][DWIDTH-1:0]  req_src2;
   aluop_sel_t              req_sel [2];
   logic [1:0]              rsp_valid;
   logic [1:0]              rsp_ready;
   logic [DWIDTH-1:0]       rsp_res;
   logic                    rsp_res_is_0;

   // Requester side drives operations and consumes results.
   modport master (
      output req_valid, req_src1, req_src2, req_sel, rsp_ready,
      input  req_ready, rsp_valid, rsp_res, rsp_res_is_0
   );

   modport slave (
      input  req_valid, req_src1, req_src2, req_sel, rsp_ready,
      output req_ready, rsp_valid, rsp_res, rsp_res_is_0
   );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters, with a
// registered result held until its owner takes it.
module alu_arbiter_alu
   import typedefs_pkg::*;
#(
   parameter int DWIDTH = 8
) (
   input  logic [DWIDTH-1:0] src1,
   input  logic [DWIDTH-1:0] src2,
   input  aluop_sel_t        sel,
   output logic [DWIDTH-1:0] res,
   output logic              res_is_0
);
   // Unassigned encodings fall through to zero rather than flagging an error.
   always_comb begin
      res = '0;
      case (sel)
         ALU_AND: res = src1 & src2;
         ALU_OR:  res = src1 | src2;
         ALU_ADD: res = src1 + src2;
         ALU_XOR: res = src1 ^ src2;
         ALU_SUB: res = src1 - src2;
         ALU_SLT: res = {{(DWIDTH-1){1'b0}}, (src1 < src2)};
         default: res = '0;
      endcase
   end

   assign res_is_0 = (res == '0);
endmodule

module alu_arbiter
   import typedefs_pkg::*;
#(
   parameter int DWIDTH = 8
) (
   input  logic          clk,
   input  logic          rst,
   alu_arbiter_if.slave  bus,
   output logic          busy
);
   typedef enum logic {IDLE, RESP} state_t;

   state_t            state;
   state_t            state_next;
   logic              rr_ptr;
   logic              grant;
   logic              can_accept;
   logic              handshake;
   logic              accept;
   logic [1:0]        ready;
   logic [DWIDTH-1:0] alu_res;
   logic              alu_res_is_0;

   alu_arbiter_alu #(.DWIDTH(DWIDTH)) u_alu (
      .src1     (bus.req_src1[grant]),
      .src2     (bus.req_src2[grant]),
      .sel      (bus.req_sel[grant]),
      .res      (alu_res),
      .res_is_0 (alu_res_is_0)
   );

   // A held result frees the slot in the same cycle its owner consumes it,
   // which is what allows one operation per cycle under contention.
   always_comb begin
      handshake  = |(bus.rsp_valid & bus.rsp_ready);
      can_accept = (state == IDLE) || handshake;
      grant      = 1'b0;
      if (&bus.req_valid)
         grant = rr_ptr;
      else if (bus.req_valid[1])
         grant = 1'b1;
      ready = '0;
      if (can_accept && !rst)
         ready = (grant ? 2'b10 : 2'b01) & bus.req_valid;
      accept = |ready;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (accept)
         state_next = RESP;
      else if (handshake)
         state_next = IDLE;
   end

   always_comb begin
      bus.req_ready = ready;
      busy          = (state == RESP);
   end

   // Result registers only move on accept or on consumption; otherwise held.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr           <= 1'b0;
         bus.rsp_valid    <= 2'b00;
         bus.rsp_res      <= '0;
         bus.rsp_res_is_0 <= 1'b0;
      end else if (accept) begin
         rr_ptr           <= ~grant;
         bus.rsp_valid    <= grant ? 2'b10 : 2'b01;
         bus.rsp_res      <= alu_res;
         bus.rsp_res_is_0 <= alu_res_is_0;
      end else if (handshake) begin
         bus.rsp_valid    <= 2'b00;
      end
   end
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed checks of the two-requester ALU arbiter: reset, single ops,
// contention, backpressure, wrong-owner consume and arithmetic edge cases.
module tb_alu_arbiter;
   import typedefs_pkg::*;

   logic clk;
   logic rst;
   logic busy;
   int   checks;
   int   passes;
   int   fails;
   aluop_sel_t undef_sel;

   alu_arbiter_if #(.DWIDTH(8)) bus ();

   alu_arbiter #(.DWIDTH(8)) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus.slave),
      .busy (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic apply_stimulus(
      input logic [1:0] valid,
      input aluop_sel_t sel0, input logic [7:0] a0, input logic [7:0] b0,
      input aluop_sel_t sel1, input logic [7:0] a1, input logic [7:0] b1,
      input logic [1:0] rready
   );
      bus.req_valid   = valid;
      bus.req_sel[0]  = sel0;
      bus.req_src1[0] = a0;
      bus.req_src2[0] = b0;
      bus.req_sel[1]  = sel1;
      bus.req_src1[1] = a1;
      bus.req_src2[1] = b1;
      bus.rsp_ready   = rready;
      #1;
   endtask

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      checks++;
      assert (observed === expected) passes++;
      else begin
         fails++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic check_rsp(input string tag, input logic [1:0] valid,
                            input logic [7:0] res, input logic is0, input logic bsy);
      check_output({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'(valid));
      check_output({tag, " rsp_res"}, 32'(bus.rsp_res), 32'(res));
      check_output({tag, " rsp_res_is_0"}, 32'(bus.rsp_res_is_0), 32'(is0));
      check_output({tag, " busy"}, 32'(busy), 32'(bsy));
   endtask

   initial begin
      checks = 0;
      passes = 0;
      fails  = 0;
      undef_sel = aluop_sel_t'(3'd4);
      rst = 1'b1;
      apply_stimulus(2'b00, ALU_AND, 8'h00, 8'h00, ALU_AND, 8'h00, 8'h00, 2'b00);
      repeat (2) @(negedge clk);
      check_rsp("reset", 2'b00, 8'h00, 1'b0, 1'b0);
      check_output("reset req_ready", 32'(bus.req_ready), 32'd0);
      rst = 1'b0;

      // Contention: grants 0,1,0 with one result per cycle.
      @(negedge clk);
      apply_stimulus(2'b11, ALU_SUB, 8'd5, 8'd5, ALU_SLT, 8'd3, 8'd250, 2'b11);
      check_output("t3 grant0 req_ready", 32'(bus.req_ready), 32'h1);
      @(negedge clk);
      #1;
      check_rsp("t3 sub", 2'b01, 8'h00, 1'b1, 1'b1);
      check_output("t3 grant1 req_ready", 32'(bus.req_ready), 32'h2);
      @(negedge clk);
      #1;
      check_rsp("t3 slt", 2'b10, 8'h01, 1'b0, 1'b1);
      check_output("t3 grant0b req_ready", 32'(bus.req_ready), 32'h1);
      @(negedge clk);
      apply_stimulus(2'b00, ALU_SUB, 8'd5, 8'd5, ALU_SLT, 8'd3, 8'd250, 2'b11);
      check_rsp("t3 sub again", 2'b01, 8'h00, 1'b1, 1'b1);
      @(negedge clk);
      #1;
      check_rsp("t3 drained", 2'b00, 8'h00, 1'b1, 1'b0);

      // Single op from requester 0 with latency of one cycle.
      apply_stimulus(2'b01, ALU_ADD, 8'h7F, 8'h01, ALU_AND, 8'h00, 8'h00, 2'b01);
      check_output("t2 req_ready", 32'(bus.req_ready), 32'h1);
      @(negedge clk);
      apply_stimulus(2'b00, ALU_ADD, 8'h7F, 8'h01, ALU_AND, 8'h00, 8'h00, 2'b01);
      check_rsp("t2 add", 2'b01, 8'h80, 1'b0, 1'b1);
      @(negedge clk);
      #1;
      check_rsp("t2 idle", 2'b00, 8'h80, 1'b0, 1'b0);

      // Backpressure on requester 1's result blocks requester 0.
      apply_stimulus(2'b10, ALU_AND, 8'h00, 8'h00, ALU_XOR, 8'hF0, 8'hFF, 2'b00);
      check_output("t4 r1 req_ready", 32'(bus.req_ready), 32'h2);
      @(negedge clk);
      apply_stimulus(2'b01, ALU_ADD, 8'h02, 8'h03, ALU_XOR, 8'hF0, 8'hFF, 2'b00);
      for (int i = 0; i < 3; i++) begin
         check_rsp($sformatf("t4 hold%0d", i), 2'b10, 8'h0F, 1'b0, 1'b1);
         check_output($sformatf("t4 hold%0d req_ready", i), 32'(bus.req_ready), 32'h0);
         @(negedge clk);
         #1;
      end
      apply_stimulus(2'b01, ALU_ADD, 8'h02, 8'h03, ALU_XOR, 8'hF0, 8'hFF, 2'b10);
      check_output("t4 release req_ready", 32'(bus.req_ready), 32'h1);
      @(negedge clk);

      // Consume strobe on the non-owning bit must be ignored.
      apply_stimulus(2'b10, ALU_ADD, 8'h02, 8'h03, ALU_OR, 8'h11, 8'h22, 2'b10);
      check_rsp("t4 back2back", 2'b01, 8'h05, 1'b0, 1'b1);
      check_output("t5 req_ready", 32'(bus.req_ready), 32'h0);
      @(negedge clk);
      #1;
      check_rsp("t5 held", 2'b01, 8'h05, 1'b0, 1'b1);
      apply_stimulus(2'b00, ALU_ADD, 8'h02, 8'h03, ALU_OR, 8'h11, 8'h22, 2'b01);
      @(negedge clk);
      #1;
      check_rsp("t5 consumed", 2'b00, 8'h05, 1'b0, 1'b0);

      // Wrap-around add, then an undefined opcode back-to-back.
      apply_stimulus(2'b10, ALU_AND, 8'h00, 8'h00, ALU_ADD, 8'hFF, 8'h01, 2'b10);
      @(negedge clk);
      apply_stimulus(2'b01, undef_sel, 8'h12, 8'h34, ALU_ADD, 8'hFF, 8'h01, 2'b10);
      check_rsp("t6 wrap", 2'b10, 8'h00, 1'b1, 1'b1);
      check_output("t6 undef req_ready", 32'(bus.req_ready), 32'h1);
      @(negedge clk);
      apply_stimulus(2'b10, undef_sel, 8'h12, 8'h34, ALU_AND, 8'h0F, 8'h3C, 2'b01);
      check_rsp("t6 undef", 2'b01, 8'h00, 1'b1, 1'b1);
      @(negedge clk);
      apply_stimulus(2'b11, undef_sel, 8'h12, 8'h34, ALU_AND, 8'h0F, 8'h3C, 2'b00);
      check_rsp("t1 pre-reset", 2'b10, 8'h0C, 1'b0, 1'b1);

      // Reset in the middle of a held response clears everything at once.
      rst = 1'b1;
      #1;
      check_rsp("t1 reset", 2'b00, 8'h00, 1'b0, 1'b0);
      check_output("t1 reset req_ready", 32'(bus.req_ready), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_output("t1 post-reset grant", 32'(bus.req_ready), 32'h1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
